// File: rtl/sram_read_arbiter.sv
// Two-port read-only arbiter for the asynchronous SRAM. It issues one read at a time,
// holds the address for WAIT_CYCLES cycles, then returns a one-cycle response pulse.
module sram_read_arbiter #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              busy,
  output logic              sram_WE,
  output logic              sram_CE,
  output logic              sram_OE,
  output logic              sram_LB,
  output logic              sram_UB,
  output logic [ADDR_W-1:0] SRAM_A,
  input  logic [DATA_W-1:0] SRAM_D
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES == 0) begin : g_bad_wait
    $error("sram_read_arbiter: WAIT_CYCLES must be >= 1");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_grant;
  logic               r_port;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               w_grant;
  logic               w_accept;
  logic               w_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant (round-robin on contention), readys and next state
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = ~r_last_grant;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    if (req0_valid ^ req1_valid) w_grant = req1_valid;
    case (r_state)
      ST_IDLE: begin
        req0_ready = ~w_grant;
        req1_ready = w_grant;
        w_accept   = (req0_valid & ~w_grant) | (req1_valid & w_grant);
        if (w_accept) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_done = (r_wait_cnt == '0);
        if (w_done) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (r_state == ST_WAIT);

  // Address, wait counter and per-port response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SRAM_A       <= '0;
      r_port       <= 1'b0;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp1_data    <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (w_accept) begin
        SRAM_A       <= w_grant ? req1_addr : req0_addr;
        r_port       <= w_grant;
        r_last_grant <= w_grant;
        r_wait_cnt   <= CNT_LOAD;
      end else if (w_done) begin
        if (r_port) begin
          rsp1_data  <= SRAM_D;
          rsp1_valid <= 1'b1;
        end else begin
          rsp0_data  <= SRAM_D;
          rsp0_valid <= 1'b1;
        end
      end else if (busy) begin
        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
      end
    end
  end

  assign sram_WE = 1'b1;
  assign sram_CE = 1'b0;
  assign sram_OE = 1'b0;
  assign sram_LB = 1'b0;
  assign sram_UB = 1'b0;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Scoreboard bench for sram_read_arbiter: default build plus a WAIT_CYCLES=1 build.
module tb_sram_read_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [DW-1:0] rsp0_data, rsp1_data, SRAM_D;
  logic [AW-1:0] SRAM_A;
  logic          sram_WE, sram_CE, sram_OE, sram_LB, sram_UB;

  logic          b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic [AW-1:0] b_req0_addr = '0, b_req1_addr = '0;
  logic          b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy;
  logic [DW-1:0] b_rsp0_data, b_rsp1_data, b_SRAM_D;
  logic [AW-1:0] b_SRAM_A;
  logic          b_WE, b_CE, b_OE, b_LB, b_UB;

  // Directed SRAM contents, hand-chosen per test.
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    case (a)
      18'h00005: return 16'hA5C3;
      18'h00010: return 16'h1111;
      18'h00020: return 16'h2222;
      18'h00030: return 16'h1234;
      18'h00040: return 16'hBEEF;
      18'h3FFFF: return 16'hC0DE;
      default:   return 16'hDEAD;
    endcase
  endfunction

  assign SRAM_D   = mem(SRAM_A);
  assign b_SRAM_D = mem(b_SRAM_A);

  sram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .busy(busy), .sram_WE(sram_WE), .sram_CE(sram_CE), .sram_OE(sram_OE),
    .sram_LB(sram_LB), .sram_UB(sram_UB), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D)
  );

  sram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_ready(b_req0_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
    .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_ready(b_req1_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
    .busy(b_busy), .sram_WE(b_WE), .sram_CE(b_CE), .sram_OE(b_OE),
    .sram_LB(b_LB), .sram_UB(b_UB), .SRAM_A(b_SRAM_A), .SRAM_D(b_SRAM_D)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            rsp_cnt = 0;
  logic [AW-1:0] cur_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: records accepts into the scoreboard and checks every response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (req0_ready || req1_ready) check("ready_excl", 32'(req0_ready & req1_ready), 0);
      if (busy) begin
        check("ready_in_wait", 32'(req0_ready | req1_ready), 0);
        check("sram_a_hold", 32'(SRAM_A), 32'(cur_addr));
      end
      if (rsp0_valid) begin
        rsp_cnt++;
        if (q0.size() == 0) check("rsp0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          check("rsp0_data", 32'(rsp0_data), 32'(e.data));
          check("rsp0_latency", 32'(cyc), 32'(e.due));
        end
      end
      if (rsp1_valid) begin
        rsp_cnt++;
        if (q1.size() == 0) check("rsp1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          check("rsp1_data", 32'(rsp1_data), 32'(e.data));
          check("rsp1_latency", 32'(cyc), 32'(e.due));
        end
      end
      if (req0_valid && req0_ready) begin
        q0.push_back('{data: mem(req0_addr), due: cyc + 1 + int'(W)});
        cur_addr = req0_addr;
      end
      if (req1_valid && req1_ready) begin
        q1.push_back('{data: mem(req1_addr), due: cyc + 1 + int'(W)});
        cur_addr = req1_addr;
      end
    end
  end

  task automatic read(input int p, input logic [AW-1:0] a, output int waited);
    int n = 0;
    @(posedge clk); #1;
    if (p == 0) begin req0_valid = 1'b1; req0_addr = a; end
    else        begin req1_valid = 1'b1; req1_addr = a; end
    @(negedge clk);
    while (!(p == 0 ? req0_ready : req1_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 1, 0);
    waited = n;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q0.size() != 0 || q1.size() != 0) && n < 50);
    if (n >= 50) check("drain_timeout", 1, 0);
  endtask

  // Both ports held valid for n_acc accepts; winners must alternate from first_w.
  task automatic contend(input int n_acc, input int first_w);
    int got = 0, t = 0, last_cyc = -1, w;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 18'h10;
    req1_valid = 1'b1; req1_addr = 18'h20;
    while (got < n_acc && t < 100) begin
      @(negedge clk);
      t++;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        w = req1_ready ? 1 : 0;
        check("grant_order", 32'(w), 32'((first_w + got) % 2));
        if (last_cyc >= 0) check("grant_spacing", 32'(cyc - last_cyc), 32'(W + 1));
        last_cyc = cyc;
        got++;
      end
    end
    check("grant_count", 32'(got), 32'(n_acc));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int wt;
    int n;
    int cnt_before;

    #35;
    check("rst_sram_a", 32'(SRAM_A), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
    check("rst_rsp_data", 32'({rsp0_data, rsp1_data}), 0);
    check("sram_ctrl", 32'({sram_WE, sram_CE, sram_OE, sram_LB, sram_UB}), 32'h10);
    @(negedge clk); #1 rst_n = 1'b1;

    read(0, 18'h5, wt);
    check("first_idle_ready", 32'(wt), 0);
    drain();
    check("single_rsp0_data", 32'(rsp0_data), 32'hA5C3);

    read(1, 18'h30, wt);
    drain();
    read(0, 18'h40, wt);
    drain();
    check("stale_rsp1_hold", 32'(rsp1_data), 32'h1234);
    check("stale_rsp0_new", 32'(rsp0_data), 32'hBEEF);

    read(1, 18'h20, wt);
    drain();
    contend(1, 0);
    drain();
    read(0, 18'h10, wt);
    drain();
    contend(1, 1);
    drain();

    contend(4, 0);
    drain();
    check("contend_rsp0_data", 32'(rsp0_data), 32'h1111);
    check("contend_rsp1_data", 32'(rsp1_data), 32'h2222);

    // Reset in the middle of a port 1 read: no response may follow.
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_addr = 18'h20;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    cnt_before = rsp_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sram_a", 32'(SRAM_A), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
    check("midrst_rsp_data", 32'({rsp0_data, rsp1_data}), 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_cnt - cnt_before), 0);

    read(0, 18'h3FFFF, wt);
    drain();
    check("max_addr_data", 32'(rsp0_data), 32'hC0DE);

    // WAIT_CYCLES=1 build: two-cycle latency, full-width address.
    @(posedge clk); #1;
    b_req0_valid = 1'b1; b_req0_addr = 18'h3FFFF;
    n = 0;
    @(negedge clk);
    while (!b_req0_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w1_ready", 32'(b_req0_ready), 1);
    @(posedge clk); #1 b_req0_valid = 1'b0;
    @(negedge clk);
    check("w1_addr", 32'(b_SRAM_A), 32'h3FFFF);
    check("w1_early", 32'(b_rsp0_valid), 0);
    @(negedge clk);
    check("w1_rsp_valid", 32'(b_rsp0_valid), 1);
    check("w1_rsp_data", 32'(b_rsp0_data), 32'hC0DE);
    check("w1_rsp1_quiet", 32'(b_rsp1_valid), 0);
    @(negedge clk);
    check("w1_pulse_end", 32'(b_rsp0_valid), 0);

    check("sb_q0_empty", 32'(q0.size()), 0);
    check("sb_q1_empty", 32'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
